alu_mc: RTL and testbench

Parametrised, multi-cycle successor to the 4-bit combinational ALU. It takes `WIDTH`-bit operands and a 4-bit opcode through a valid/ready input handshake, computes single-cycle logic, arithmetic and barrel-shift operations plus an iterative shift-add multiply, and returns a registered result with Z/C/N/V flags through a valid/ready output handshake. It sits between an issue stage and a writeback stage, so back-pressure and multi-cycle latency are handled locally.

---
 rtl/alu_pkg.sv | 35 +++
 rtl/alu_mc_if.sv | 29 ++
 rtl/alu_mul_seq.sv | 51 +++++
 rtl/alu_mc.sv | 126 ++++++++++++
 tb/tb_alu_mc.sv | 186 ++++++++++++++++++
 5 files changed

// File: rtl/alu_pkg.sv
// Shared types for the multi-cycle ALU: opcodes, flag bundle and FSM states.
package alu_pkg;

   typedef enum logic [3:0] {
      OP_ADD  = 4'd0,
      OP_SUB  = 4'd1,
      OP_AND  = 4'd2,
      OP_OR   = 4'd3,
      OP_XOR  = 4'd4,
      OP_NOR  = 4'd5,
      OP_SHL  = 4'd6,
      OP_SHR  = 4'd7,
      OP_SAR  = 4'd8,
      OP_MUL  = 4'd9,
      OP_SLT  = 4'd10,
      OP_SLTU = 4'd11
   } alu_op_e;

   typedef struct packed {
      logic z;
      logic c;
      logic n;
      logic v;
   } alu_flags_t;

   typedef enum logic [1:0] {
      ST_IDLE,
      ST_BUSY,
      ST_DONE
   } alu_state_e;

   // Flag value held while no result has been produced yet (result 0 => Zero set).
   localparam alu_flags_t FLAGS_RESET = '{z: 1'b1, c: 1'b0, n: 1'b0, v: 1'b0};

endpackage

// File: rtl/alu_mc_if.sv
// Issue/writeback handshake bundle of the multi-cycle ALU.
interface alu_mc_if #(parameter int WIDTH = 8);

   logic             in_valid;
   logic             in_ready;
   logic [WIDTH-1:0] A;
   logic [WIDTH-1:0] B;
   logic [3:0]       ALU_Sel;
   logic             out_valid;
   logic             out_ready;
   logic [WIDTH-1:0] ALU_Result;
   logic             Zero;
   logic             Carry;
   logic             Negative;
   logic             Overflow;

   // Issue stage / writeback stage side.
   modport master (
      output in_valid, A, B, ALU_Sel, out_ready,
      input  in_ready, out_valid, ALU_Result, Zero, Carry, Negative, Overflow
   );

   // ALU side.
   modport slave (
      input  in_valid, A, B, ALU_Sel, out_ready,
      output in_ready, out_valid, ALU_Result, Zero, Carry, Negative, Overflow
   );

endinterface

// File: rtl/alu_mul_seq.sv
// Iterative shift-add multiplier: one partial product per cycle, WIDTH cycles.
// done is asserted combinationally during the final iteration so the caller
// can register the finished product on the same edge the last add completes.
module alu_mul_seq #(
   parameter int WIDTH = 8
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             start,
   input  logic [WIDTH-1:0] a,
   input  logic [WIDTH-1:0] b,
   output logic             done,
   output logic [WIDTH-1:0] product,
   output logic             upper_nz
);

   localparam int CW = $clog2(WIDTH) + 1;

   logic [2*WIDTH-1:0] a_q;
   logic [2*WIDTH-1:0] acc_q;
   logic [2*WIDTH-1:0] acc_next;
   logic [WIDTH-1:0]   b_q;
   logic [CW-1:0]      cnt_q;

   assign acc_next = acc_q + (b_q[0] ? a_q : '0);
   assign done     = (cnt_q == CW'(1));
   assign product  = acc_next[WIDTH-1:0];
   assign upper_nz = |acc_next[2*WIDTH-1:WIDTH];

   // Load operands on start, then add/shift once per cycle until the counter empties.
   // NOTE: sequential state uses <= so every register samples pre-edge values.
   always_ff @(posedge clk) begin
      if (rst) begin
         a_q   <= '0;
         b_q   <= '0;
         acc_q <= '0;
         cnt_q <= '0;
      end else if (start) begin
         a_q   <= {{WIDTH{1'b0}}, a};
         b_q   <= b;
         acc_q <= '0;
         cnt_q <= CW'(WIDTH);
      end else if (cnt_q != '0) begin
         acc_q <= acc_next;
         a_q   <= a_q << 1;
         b_q   <= b_q >> 1;
         cnt_q <= cnt_q - CW'(1);
      end
   end

endmodule

// File: rtl/alu_mc.sv
// Multi-cycle ALU: single-cycle logic/arith/shift ops, sequential multiply,
// registered result and flags behind valid/ready handshakes on both sides.
module alu_mc #(
   parameter int WIDTH = 8
) (
   input logic     clk,
   input logic     rst,
   alu_mc_if.slave bus
);

   import alu_pkg::*;

   localparam int SW = $clog2(WIDTH);

   alu_state_e       state_q, state_d;
   alu_op_e          op;
   logic [WIDTH-1:0] res_q, alu_res, mul_res;
   alu_flags_t       flags_q, alu_flags;
   logic [WIDTH:0]   sum, diff;
   logic [SW-1:0]    shamt;
   logic             in_ready, accept, load_alu, mul_start, mul_done, mul_carry;

   assign op     = alu_op_e'(bus.ALU_Sel);
   assign shamt  = bus.B[SW-1:0];
   assign sum    = {1'b0, bus.A} + {1'b0, bus.B};
   assign diff   = {1'b0, bus.A} - {1'b0, bus.B};

   // A slot opens when idle, or when the held result is being consumed this cycle.
   assign in_ready = (state_q == ST_IDLE) || ((state_q == ST_DONE) && bus.out_ready);
   assign accept   = bus.in_valid && in_ready;

   alu_mul_seq #(.WIDTH(WIDTH)) u_mul (
      .clk      (clk),
      .rst      (rst),
      .start    (mul_start),
      .a        (bus.A),
      .b        (bus.B),
      .done     (mul_done),
      .product  (mul_res),
      .upper_nz (mul_carry)
   );

   // Single-cycle datapath; illegal opcodes fall through to result 0.
   // NOTE: every always_comb output gets a default first so no latch is inferred.
   always_comb begin
      alu_res   = '0;
      alu_flags = '0;
      case (op)
         OP_ADD: begin
            alu_res     = sum[WIDTH-1:0];
            alu_flags.c = sum[WIDTH];
            alu_flags.v = (bus.A[WIDTH-1] == bus.B[WIDTH-1]) && (sum[WIDTH-1] != bus.A[WIDTH-1]);
         end
         OP_SUB: begin
            alu_res     = diff[WIDTH-1:0];
            alu_flags.c = diff[WIDTH];
            alu_flags.v = (bus.A[WIDTH-1] != bus.B[WIDTH-1]) && (diff[WIDTH-1] != bus.A[WIDTH-1]);
         end
         OP_AND:  alu_res = bus.A & bus.B;
         OP_OR:   alu_res = bus.A | bus.B;
         OP_XOR:  alu_res = bus.A ^ bus.B;
         OP_NOR:  alu_res = ~(bus.A | bus.B);
         OP_SHL:  alu_res = bus.A << shamt;
         OP_SHR:  alu_res = bus.A >> shamt;
         OP_SAR:  alu_res = WIDTH'($signed(bus.A) >>> shamt);
         OP_SLT:  alu_res = {{(WIDTH-1){1'b0}}, ($signed(bus.A) < $signed(bus.B))};
         OP_SLTU: alu_res = {{(WIDTH-1){1'b0}}, diff[WIDTH]};
         default: alu_res = '0;
      endcase
      alu_flags.z = (alu_res == '0);
      alu_flags.n = alu_res[WIDTH-1];
   end

   // Next-state logic: route accepted ops to DONE or BUSY, drain DONE on out_ready.
   always_comb begin
      state_d   = state_q;
      load_alu  = 1'b0;
      mul_start = 1'b0;
      case (state_q)
         ST_IDLE, ST_DONE: begin
            if (accept) begin
               if (op == OP_MUL) begin
                  mul_start = 1'b1;
                  state_d   = ST_BUSY;
               end else begin
                  load_alu = 1'b1;
                  state_d  = ST_DONE;
               end
            end else if ((state_q == ST_DONE) && bus.out_ready) begin
               state_d = ST_IDLE;
            end
         end
         ST_BUSY: if (mul_done) state_d = ST_DONE;
         default: state_d = ST_IDLE;
      endcase
   end

   // FSM state register.
   always_ff @(posedge clk) begin
      if (rst) state_q <= ST_IDLE;
      else     state_q <= state_d;
   end

   // Output register: written only with a finished result, so nothing partial leaks out.
   always_ff @(posedge clk) begin
      if (rst) begin
         res_q   <= '0;
         flags_q <= FLAGS_RESET;
      end else if (load_alu) begin
         res_q   <= alu_res;
         flags_q <= alu_flags;
      end else if ((state_q == ST_BUSY) && mul_done) begin
         res_q   <= mul_res;
         flags_q <= '{z: (mul_res == '0), c: mul_carry, n: mul_res[WIDTH-1], v: 1'b0};
      end
   end

   assign bus.in_ready   = in_ready;
   assign bus.out_valid  = (state_q == ST_DONE);
   assign bus.ALU_Result = res_q;
   assign bus.Zero       = flags_q.z;
   assign bus.Carry      = flags_q.c;
   assign bus.Negative   = flags_q.n;
   assign bus.Overflow   = flags_q.v;

endmodule

// File: tb/tb_alu_mc.sv
// Scoreboard bench for alu_mc: stimulus pushes hand-computed results, a
// monitor pops and compares whenever a result is handed over.
module tb_alu_mc;

   localparam int WIDTH = 8;

   typedef struct {
      string      tag;
      logic [7:0] res;
      logic [3:0] flags;   // {Z, C, N, V}
   } exp_item_t;

   logic clk = 1'b0;
   logic rst = 1'b1;
   int   tests = 0;
   int   fails = 0;
   exp_item_t exp_q[$];

   always #5 clk = ~clk;

   alu_mc_if #(.WIDTH(WIDTH)) bus ();

   alu_mc #(.WIDTH(WIDTH)) dut (
      .clk (clk),
      .rst (rst),
      .bus (bus)
   );

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
      tests++;
      if (act !== req) begin
         fails++;
         $display("FAIL %s: got %0h, expected %0h", name, act, req);
      end
   endtask

   // Offer one op, optionally scoreboard its result, return #1 after the accepting edge.
   task automatic issue(input string tag, input logic [3:0] op, input logic [7:0] a,
                        input logic [7:0] b, input logic [7:0] res, input logic [3:0] fl,
                        input bit expect_out);
      exp_item_t e;
      int n;
      if (expect_out) begin
         e.tag = tag; e.res = res; e.flags = fl;
         exp_q.push_back(e);
      end
      bus.in_valid = 1'b1;
      bus.ALU_Sel  = op;
      bus.A        = a;
      bus.B        = b;
      n = 0;
      while (!bus.in_ready && n < 50) begin
         @(posedge clk); #1;
         n++;
      end
      if (n == 50) begin
         tests++; fails++;
         $display("FAIL %s_accept: in_ready never rose within 50 cycles", tag);
      end
      @(posedge clk); #1;
      bus.in_valid = 1'b0;
      bus.A        = ~a;   // garbage after acceptance must not disturb the op
      bus.B        = ~b;
      bus.ALU_Sel  = 4'hF;
   endtask

   // Multiply with latency check: busy for WIDTH cycles, result after edge N+WIDTH.
   task automatic run_mul(input string tag, input logic [7:0] a, input logic [7:0] b,
                          input logic [7:0] res, input logic [3:0] fl);
      issue(tag, 4'd9, a, b, res, fl, 1'b1);
      for (int i = 0; i < WIDTH; i++) begin
         check({tag, "_busy"}, {30'd0, bus.in_ready, bus.out_valid}, 32'd0);
         @(posedge clk); #1;
      end
      check({tag, "_latency"}, 32'(bus.out_valid), 32'd1);
   endtask

   // Monitor: one pop per handover (sampled on the falling edge before the taking edge).
   initial begin
      exp_item_t e;
      forever begin
         @(negedge clk);
         if (!rst && bus.out_valid && bus.out_ready) begin
            if (exp_q.size() == 0) begin
               tests++; fails++;
               $display("FAIL unexpected_output: got %0h with empty scoreboard", bus.ALU_Result);
            end else begin
               e = exp_q.pop_front();
               check({e.tag, "_result"}, 32'(bus.ALU_Result), 32'(e.res));
               check({e.tag, "_flags"},
                     {28'd0, bus.Zero, bus.Carry, bus.Negative, bus.Overflow}, 32'(e.flags));
            end
         end
      end
   end

   initial begin
      int n;
      bus.in_valid  = 1'b0;
      bus.out_ready = 1'b1;
      bus.A         = '0;
      bus.B         = '0;
      bus.ALU_Sel   = '0;
      rst           = 1'b1;
      repeat (2) @(posedge clk);
      #1 rst = 1'b0;

      check("reset_out_valid", 32'(bus.out_valid), 32'd0);
      check("reset_in_ready",  32'(bus.in_ready),  32'd1);
      check("reset_result",    32'(bus.ALU_Result), 32'd0);
      check("reset_flags", {28'd0, bus.Zero, bus.Carry, bus.Negative, bus.Overflow}, 32'b1000);

      // Single-cycle ops, issued back to back.
      issue("add_ff_01", 4'd0, 8'hFF, 8'h01, 8'h00, 4'b1100, 1'b1);
      check("add_latency", 32'(bus.out_valid), 32'd1);
      issue("sub_80_01",  4'd1,  8'h80, 8'h01, 8'h7F, 4'b0001, 1'b1);
      issue("slt_80_01",  4'd10, 8'h80, 8'h01, 8'h01, 4'b0000, 1'b1);
      issue("sltu_80_01", 4'd11, 8'h80, 8'h01, 8'h00, 4'b1000, 1'b1);
      issue("sar_90_0a",  4'd8,  8'h90, 8'h0A, 8'hE4, 4'b0010, 1'b1);
      issue("shl_01_07",  4'd6,  8'h01, 8'h07, 8'h80, 4'b0010, 1'b1);
      issue("shr_90_0c",  4'd7,  8'h90, 8'h0C, 8'h09, 4'b0000, 1'b1);
      issue("and_f0_3c",  4'd2,  8'hF0, 8'h3C, 8'h30, 4'b0000, 1'b1);
      issue("or_f0_0f",   4'd3,  8'hF0, 8'h0F, 8'hFF, 4'b0010, 1'b1);
      issue("xor_aa_ff",  4'd4,  8'hAA, 8'hFF, 8'h55, 4'b0000, 1'b1);
      issue("nor_0f_f0",  4'd5,  8'h0F, 8'hF0, 8'h00, 4'b1000, 1'b1);
      issue("add_7f_01",  4'd0,  8'h7F, 8'h01, 8'h80, 4'b0011, 1'b1);
      issue("sub_01_02",  4'd1,  8'h01, 8'h02, 8'hFF, 4'b0110, 1'b1);

      // Multiplies.
      run_mul("mul_0f_11", 8'h0F, 8'h11, 8'hFF, 4'b0010);
      run_mul("mul_10_10", 8'h10, 8'h10, 8'h00, 4'b1100);

      // Back-pressure: let the last result drain, then stall an ADD for 5 cycles.
      @(posedge clk); #1;
      bus.out_ready = 1'b0;
      issue("add_12_34", 4'd0, 8'h12, 8'h34, 8'h46, 4'b0000, 1'b1);
      exp_q.push_back('{tag: "xor_5a_0f", res: 8'h55, flags: 4'b0000});
      bus.in_valid = 1'b1;
      bus.ALU_Sel  = 4'd4;
      bus.A        = 8'h5A;
      bus.B        = 8'h0F;
      for (int i = 0; i < 5; i++) begin
         check("stall_in_ready", 32'(bus.in_ready), 32'd0);
         check("stall_out_valid", 32'(bus.out_valid), 32'd1);
         check("stall_result", 32'(bus.ALU_Result), 32'h46);
         check("stall_flags", {28'd0, bus.Zero, bus.Carry, bus.Negative, bus.Overflow}, 32'd0);
         @(posedge clk); #1;
      end
      bus.out_ready = 1'b1;
      #1;
      check("release_in_ready", 32'(bus.in_ready), 32'd1);
      @(posedge clk); #1;
      bus.in_valid = 1'b0;
      check("xor_next_valid",  32'(bus.out_valid), 32'd1);
      check("xor_next_result", 32'(bus.ALU_Result), 32'h55);

      // Reset in the third cycle of a multiply: no result may ever appear.
      issue("mul_rst", 4'd9, 8'h03, 8'h05, 8'h0F, 4'b0000, 1'b0);
      @(posedge clk);
      @(posedge clk); #1;
      rst = 1'b1;
      @(posedge clk); #1;
      rst = 1'b0;
      check("midmul_rst_out_valid", 32'(bus.out_valid), 32'd0);
      check("midmul_rst_result",    32'(bus.ALU_Result), 32'd0);
      check("midmul_rst_in_ready",  32'(bus.in_ready),  32'd1);
      check("midmul_rst_flags", {28'd0, bus.Zero, bus.Carry, bus.Negative, bus.Overflow}, 32'b1000);

      // Illegal opcode, preceded by a nonzero result so the zero is meaningful.
      issue("or_01_02",   4'd3,  8'h01, 8'h02, 8'h03, 4'b0000, 1'b1);
      issue("illegal_13", 4'd13, 8'hFF, 8'hFF, 8'h00, 4'b1000, 1'b1);
      check("illegal_latency", 32'(bus.out_valid), 32'd1);

      // Drain the scoreboard with a bounded wait.
      n = 0;
      while (exp_q.size() != 0 && n < 50) begin
         @(posedge clk); #1;
         n++;
      end
      check("scoreboard_drained", 32'(exp_q.size()), 32'd0);

      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end

endmodule
